dual_7_seg_reader: RTL and testbench
====================================

# dual_7_seg_reader

Receive-side counterpart of the scoreboard's two-digit 7-segment driver. It samples the two 7-bit segment buses (tens and ones), decodes each pattern back to its 4-bit digit code, and debounces the pair. A new score is committed only after the pair has been stable for a configurable number of samples. It is used as an on-chip readback and monitor of the display outputs and as the input stage of a bench or companion chip that reads a scoreboard display.

## Interface
- `STABLE_CNT`, default 4: consecutive identical samples required before a commit. Legal range is 1..15.
- `clk_i` in, 1 bit: clock.
- `rst_i` in, 1 bit: reset, synchronous, active-high.
- `sample_en_i` in, 1 bit: sample strobe. The segment inputs are evaluated only on edges where this is 1.
- `seg_tens_i` in, 7 bits: tens segment pattern. bit0 = a … bit6 = g, 1 = segment on.
- `seg_ones_i` in, 7 bits: ones segment pattern, same mapping.
- `tens_o` out, 4 bits: committed tens code.
- `ones_o` out, 4 bits: committed ones code.
- `valid_o` out, 1 bit: at least one commit since reset.
- `update_o` out, 1 bit: one-cycle pulse on each commit.
- `err_o` out, 1 bit: the committed pair contains an invalid code.

## Operation
- **Decode per digit (combinational).**
  - Digits: 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9.
  - Specials: 0000000→10 (blank), 1110011→11 ('P'), 1000000→12 (dash).
  - Any other pattern→15 (invalid).
- **Candidate pair.** `new = {code(tens), code(ones)}`. Internal registers `cand` (8 bits) and `run` (4 bits, saturating at STABLE_CNT).
- **On each edge with `sample_en_i=1`:**
  - `match = (new == cand)`.
  - `run_next = match ? min(run+1, STABLE_CNT) : 1`.
  - `cand <= new`, `run <= run_next`.
- **Commit condition:** `run_next == STABLE_CNT` and the run was not already at STABLE_CNT, and either `valid_o == 0` or `new != {tens_o, ones_o}`.
- **On commit:**
  - `tens_o`/`ones_o` take `new`.
  - `valid_o <= 1`.
  - `update_o <= 1` for exactly one cycle.
  - `err_o <= (either code == 15)`.
- **Sticky outputs.** A run that re-stabilises to the already-committed value does not commit and does not pulse.
- **`sample_en_i=0`:** all state holds; `update_o` deasserts.
- **States:**
  - **WAIT:** after reset, `valid_o=0`.
  - **LOCKED:** `cand == committed` and the run is saturated.
  - **TRACK:** `cand` differs from committed, or `run < STABLE_CNT`.
  - Transitions: WAIT→LOCKED on first commit. LOCKED→TRACK on any sample differing from `cand`. TRACK→LOCKED on commit, or when a run completes on the committed value. There is no path back to WAIT except reset.

## Timing
- **Reset values:** `tens_o=0`, `ones_o=0`, `valid_o=0`, `update_o=0`, `err_o=0`. Internally `cand=8'hFF`, `run=0`.
- **Reset priority:** reset overrides `sample_en_i` on the same edge. Reset mid-run discards the run; counting restarts from the next strobe.
- **Latency:** with `sample_en_i` held at 1, a stable new pattern first sampled at edge k is committed at edge k+STABLE_CNT−1. `update_o` is high in the cycle following that edge.
- **STABLE_CNT=1:** every differing sample commits immediately. Back-to-back commits produce `update_o` high on consecutive cycles.
- **Glitches:** a single differing sample inside a run resets `run` to 1. The glitch value itself commits only if STABLE_CNT=1.
- **Saturation:** `run` never wraps. A steady input produces no further pulses regardless of duration.
- **Simultaneous change:** tens and ones are debounced as a pair. A change in either digit restarts the run for both.

## Structure
- **Shared package `seg7_pkg`:**
  - Segment pattern constants SEG_0..SEG_9, SEG_BLANK, SEG_P, SEG_DASH.
  - Code constants CODE_BLANK=10, CODE_P=11, CODE_DASH=12, CODE_INVALID=15.
  - The driver uses the same constants, so encode and decode cannot diverge.
- **Sub-module:** one combinational `seg7_to_code` (7→4 decode), instantiated twice.
- **Top:** debounce counter, candidate register, commit logic and state register.

## Test plan
- **Clean commit:** STABLE_CNT=4, tens=0000110, ones=1101101, strobe continuous → `tens_o=1`, `ones_o=5`, `valid_o=1` after the 4th strobe edge, `update_o` high for 1 cycle.
- **Glitch:**
  - Stimulus: 3× (1011011, 1001111) → 1× (1011011, 1111111) → 4× (1011011, 1001111).
  - Response: the glitch commits nothing. Exactly one commit of 2/3 occurs, on the 4th sample of the final run.
- **Invalid pattern:** tens=1010101 held for 4 samples → `tens_o=15`, `err_o=1`. A subsequent valid pair committed → `err_o=0`.
- **Specials:** (0000000, 1110011) → 10/11. Then (1000000, 0111111) → 12/0. Two `update_o` pulses total.
- **No re-commit:** committed 4/4 → 2 samples of 7 → 4/4 held for 6 samples → no `update_o`, outputs stay 4/4. Strobe gaps (`sample_en_i=0` between samples) do not break runs.
- **Reset mid-run:** 2 of 4 samples of 9/9, `rst_i` pulse, then 3 samples → no commit, all outputs at reset values. The 4th sample → commit 9/9.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared 7-segment encoding for the scoreboard driver and its readback.
//   Segment bit order: bit0 = a ... bit6 = g, 1 = segment lit.
//   Code space: 0..9 digits, 10 blank, 11 'P', 12 dash, 15 invalid.
//   Driver and reader both use these constants, so encode and decode stay
//   in lock-step.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] code_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_P     = 7'b1110011;
    localparam seg_t SEG_DASH  = 7'b1000000;

    localparam code_t CODE_BLANK   = 4'd10;
    localparam code_t CODE_P       = 4'd11;
    localparam code_t CODE_DASH    = 4'd12;
    localparam code_t CODE_INVALID = 4'd15;

    // Reader-side state: WAIT until first commit, LOCKED while the sampled
    // pair sits saturated on the committed value, TRACK otherwise.
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } rd_state_t;

    function automatic logic code_is_invalid(input code_t c);
        return c == CODE_INVALID;
    endfunction

endpackage

// File: rtl/seg7_to_code.sv
// seg7_to_code
//   Combinational 7-segment pattern to 4-bit code decoder.
//   seg  : segment pattern (bit0 = a ... bit6 = g)
//   code : 0..9, CODE_BLANK, CODE_P, CODE_DASH, or CODE_INVALID for any
//          pattern that is not an exact match.
module seg7_to_code
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_INVALID;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            SEG_P:     code = CODE_P;
            SEG_DASH:  code = CODE_DASH;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/dual_7_seg_reader.sv
// dual_7_seg_reader
//   Reads back a two-digit 7-segment display: decodes tens/ones patterns
//   and commits the pair once it has been identical for STABLE_CNT strobed
//   samples.
//   Ports:
//     clk_i, rst_i (sync, active-high)
//     sample_en_i            : inputs evaluated only when 1
//     seg_tens_i, seg_ones_i : segment patterns (bit0 = a ... bit6 = g)
//     tens_o, ones_o         : committed codes
//     valid_o                : at least one commit since reset
//     update_o               : one-cycle pulse per commit
//     err_o                  : committed pair contains an invalid code
module dual_7_seg_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 4    // 1..15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sample_en_i,
    input  logic [6:0] seg_tens_i,
    input  logic [6:0] seg_ones_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       valid_o,
    output logic       update_o,
    output logic       err_o
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CNT);

    code_t      tens_code, ones_code;
    logic [7:0] pair_new;
    logic [7:0] cand;
    logic [3:0] run;
    logic [3:0] run_next;
    logic       match;
    logic       run_done;
    logic       commit;
    rd_state_t  state;

    seg7_to_code u_tens (.seg(seg_tens_i), .code(tens_code));
    seg7_to_code u_ones (.seg(seg_ones_i), .code(ones_code));

    assign pair_new = {tens_code, ones_code};

    always_comb begin
        match    = (pair_new == cand);
        run_next = 4'd1;
        if (match)
            run_next = (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
        // A run "completes" on the sample that first reaches RUN_MAX. A
        // mismatching sample always starts a fresh run, which matters when
        // RUN_MAX is 1: run is already 1 but the new value has not been seen.
        run_done = (run_next == RUN_MAX) && (!match || run != RUN_MAX);
        commit   = run_done && (!valid_o || pair_new != {tens_o, ones_o});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand     <= 8'hFF;
            run      <= 4'd0;
            tens_o   <= 4'd0;
            ones_o   <= 4'd0;
            valid_o  <= 1'b0;
            update_o <= 1'b0;
            err_o    <= 1'b0;
            state    <= ST_WAIT;
        end else begin
            update_o <= 1'b0;
            if (sample_en_i) begin
                cand <= pair_new;
                run  <= run_next;
                if (commit) begin
                    tens_o   <= tens_code;
                    ones_o   <= ones_code;
                    valid_o  <= 1'b1;
                    update_o <= 1'b1;
                    err_o    <= code_is_invalid(tens_code) ||
                                code_is_invalid(ones_code);
                end

                case (state)
                    ST_WAIT: begin
                        if (commit)
                            state <= ST_LOCKED;
                    end
                    ST_LOCKED: begin
                        if (!match)
                            state <= ST_TRACK;
                    end
                    default: begin
                        // Either a fresh commit or a run that settled back
                        // onto the committed value re-locks.
                        if (commit || (run_done && pair_new == {tens_o, ones_o}))
                            state <= ST_LOCKED;
                        else
                            state <= ST_TRACK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dual_7_seg_reader.sv
module tb_dual_7_seg_reader;
    import seg7_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       sample_en_i = 1'b0;
    logic [6:0] seg_tens_i = 7'd0;
    logic [6:0] seg_ones_i = 7'd0;
    logic [3:0] tens_o, ones_o, tens1, ones1;
    logic       valid_o, update_o, err_o, valid1, update1, err1;

    int n_checks = 0;
    int n_fail   = 0;

    dual_7_seg_reader #(.STABLE_CNT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sample_en_i(sample_en_i),
        .seg_tens_i(seg_tens_i), .seg_ones_i(seg_ones_i),
        .tens_o(tens_o), .ones_o(ones_o), .valid_o(valid_o),
        .update_o(update_o), .err_o(err_o)
    );

    dual_7_seg_reader #(.STABLE_CNT(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .sample_en_i(sample_en_i),
        .seg_tens_i(seg_tens_i), .seg_ones_i(seg_ones_i),
        .tens_o(tens1), .ones_o(ones1), .valid_o(valid1),
        .update_o(update1), .err_o(err1)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus, then settle just after the edge.
    task automatic step(input logic en, input logic [6:0] t, input logic [6:0] o);
        @(negedge clk_i);
        sample_en_i = en;
        seg_tens_i  = t;
        seg_ones_i  = o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk_i);
        rst_i       = 1'b1;
        sample_en_i = en;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        rst_i       = 1'b0;
        sample_en_i = 1'b0;
    endtask

    task automatic test_reset;
        seg_tens_i = SEG_8;
        seg_ones_i = SEG_8;
        do_reset(1'b1);
        n_checks++;
        if ({tens_o, ones_o, valid_o, update_o, err_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {tens_o, ones_o, valid_o, update_o, err_o});
        end
        n_checks++;
        if ({tens1, ones1, valid1, update1, err1} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_cnt1: got %h expected 000", {tens1, ones1, valid1, update1, err1});
        end
    endtask

    task automatic test_clean_commit;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, SEG_1, SEG_5);
            n_checks++;
            if ({valid_o, update_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL clean_pre_commit[%0d]: valid/update=%b expected 00", i, {valid_o, update_o});
            end
        end
        step(1'b1, SEG_1, SEG_5);
        n_checks++;
        if ({tens_o, ones_o, valid_o, update_o, err_o} !== {4'd1, 4'd5, 3'b110}) begin
            n_fail++;
            $display("FAIL clean_commit: got t=%0d o=%0d v=%b u=%b e=%b expected 1 5 1 1 0",
                     tens_o, ones_o, valid_o, update_o, err_o);
        end
        step(1'b0, SEG_1, SEG_5);
        n_checks++;
        if ({tens_o, ones_o, valid_o, update_o} !== {4'd1, 4'd5, 2'b10}) begin
            n_fail++;
            $display("FAIL clean_pulse_width: got t=%0d o=%0d v=%b u=%b expected 1 5 1 0",
                     tens_o, ones_o, valid_o, update_o);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, SEG_1, SEG_5);
            n_checks++;
            if (update_o !== 1'b0) begin
                n_fail++;
                $display("FAIL saturation_no_pulse[%0d]: update=%b expected 0", i, update_o);
            end
        end
    endtask

    task automatic test_glitch;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, SEG_2, SEG_3);
            n_checks++;
            if (update_o !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_pre[%0d]: update=%b expected 0", i, update_o);
            end
        end
        step(1'b1, SEG_2, SEG_8);
        n_checks++;
        if (update_o !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_sample: update=%b expected 0", update_o);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, SEG_2, SEG_3);
            n_checks++;
            if (update_o !== (i == 3)) begin
                n_fail++;
                $display("FAIL glitch_run[%0d]: update=%b expected %b", i, update_o, (i == 3));
            end
        end
        n_checks++;
        if ({tens_o, ones_o, err_o} !== {4'd2, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL glitch_value: got t=%0d o=%0d e=%b expected 2 3 0", tens_o, ones_o, err_o);
        end
    endtask

    task automatic test_invalid;
        for (int i = 0; i < 4; i++) step(1'b1, 7'b1010101, SEG_0);
        n_checks++;
        if ({tens_o, ones_o, err_o, update_o} !== {4'd15, 4'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL invalid_commit: got t=%0d o=%0d e=%b u=%b expected 15 0 1 1",
                     tens_o, ones_o, err_o, update_o);
        end
        for (int i = 0; i < 4; i++) step(1'b1, SEG_3, SEG_3);
        n_checks++;
        if ({tens_o, ones_o, err_o} !== {4'd3, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL invalid_clear: got t=%0d o=%0d e=%b expected 3 3 0", tens_o, ones_o, err_o);
        end
    endtask

    task automatic test_specials;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, SEG_BLANK, SEG_P);
            if (update_o === 1'b1) pulses++;
        end
        n_checks++;
        if ({tens_o, ones_o} !== {CODE_BLANK, CODE_P}) begin
            n_fail++;
            $display("FAIL specials_blank_p: got t=%0d o=%0d expected 10 11", tens_o, ones_o);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, SEG_DASH, SEG_0);
            if (update_o === 1'b1) pulses++;
        end
        n_checks++;
        if ({tens_o, ones_o, err_o} !== {CODE_DASH, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL specials_dash_0: got t=%0d o=%0d e=%b expected 12 0 0", tens_o, ones_o, err_o);
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL specials_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_no_recommit;
        int pulses;
        for (int i = 0; i < 4; i++) step(1'b1, SEG_4, SEG_4);
        n_checks++;
        if ({tens_o, ones_o, update_o} !== {4'd4, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL recommit_setup: got t=%0d o=%0d u=%b expected 4 4 1", tens_o, ones_o, update_o);
        end
        pulses = 0;
        step(1'b1, SEG_7, SEG_7);
        if (update_o === 1'b1) pulses++;
        step(1'b1, SEG_7, SEG_7);
        if (update_o === 1'b1) pulses++;
        // Gaps between strobes must not break the run back on 4/4.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, SEG_4, SEG_4);
            if (update_o === 1'b1) pulses++;
            step(1'b0, SEG_7, SEG_7);
            if (update_o === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL no_recommit_pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if ({tens_o, ones_o, valid_o} !== {4'd4, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL no_recommit_hold: got t=%0d o=%0d v=%b expected 4 4 1", tens_o, ones_o, valid_o);
        end
        // Gapped run of a new value still commits after 4 strobes.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, SEG_6, SEG_1);
            if (update_o === 1'b1) pulses++;
            step(1'b0, SEG_9, SEG_9);
            if (update_o === 1'b1) pulses++;
        end
        n_checks++;
        if ({tens_o, ones_o, 4'(pulses)} !== {4'd6, 4'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL gapped_commit: got t=%0d o=%0d pulses=%0d expected 6 1 1", tens_o, ones_o, pulses);
        end
    endtask

    task automatic test_reset_mid_run;
        step(1'b1, SEG_9, SEG_9);
        step(1'b1, SEG_9, SEG_9);
        seg_tens_i = SEG_9;
        seg_ones_i = SEG_9;
        do_reset(1'b1);
        n_checks++;
        if ({tens_o, ones_o, valid_o, update_o, err_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected 000", {tens_o, ones_o, valid_o, update_o, err_o});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, SEG_9, SEG_9);
            n_checks++;
            if ({tens_o, ones_o, valid_o, update_o, err_o} !== 11'd0) begin
                n_fail++;
                $display("FAIL midrun_no_commit[%0d]: got %h expected 000", i,
                         {tens_o, ones_o, valid_o, update_o, err_o});
            end
        end
        step(1'b1, SEG_9, SEG_9);
        n_checks++;
        if ({tens_o, ones_o, valid_o, update_o, err_o} !== {4'd9, 4'd9, 3'b110}) begin
            n_fail++;
            $display("FAIL midrun_commit: got t=%0d o=%0d v=%b u=%b e=%b expected 9 9 1 1 0",
                     tens_o, ones_o, valid_o, update_o, err_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] tv [4];
        logic [3:0] cv [4];
        tv = '{SEG_1, SEG_2, 7'b0101010, SEG_5};
        cv = '{4'd1, 4'd2, 4'd15, 4'd5};
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, tv[i], SEG_0);
            n_checks++;
            if ({tens1, ones1, valid1, update1, err1} !== {cv[i], 4'd0, 2'b11, (i == 2)}) begin
                n_fail++;
                $display("FAIL cnt1_back_to_back[%0d]: got t=%0d o=%0d v=%b u=%b e=%b expected %0d 0 1 1 %b",
                         i, tens1, ones1, valid1, update1, err1, cv[i], (i == 2));
            end
        end
        step(1'b1, SEG_5, SEG_0);
        n_checks++;
        if ({tens1, update1, valid_o} !== {4'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL cnt1_steady: got t=%0d u=%b main_valid=%b expected 5 0 0", tens1, update1, valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_clean_commit();
        test_glitch();
        test_invalid();
        test_specials();
        test_no_recommit();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
